// File: rtl/i2s_msb_receiver_if.sv
// Show-ahead sample stream from the I2S MSB-justified receiver to its consumer.
// The master side presents the FIFO head and the slave side pops it with ready_i.
interface i2s_msb_receiver_if #(
  parameter int SAMPLE_BITS = 24,
  parameter int SLOT_W      = 1
);
  logic [SAMPLE_BITS-1:0] sample_o;
  logic [SLOT_W-1:0]      slot_o;
  logic                   valid_o;
  logic                   ready_i;

  modport master (output sample_o, output slot_o, output valid_o, input ready_i);
  modport slave  (input sample_o, input slot_o, input valid_o, output ready_i);
endinterface

// File: rtl/i2s_msb_receiver.sv
// Deserialises an MSB-justified I2S stream into {slot, sample} entries held in a
// small show-ahead FIFO. It flags framing errors and samples dropped on overflow.
module i2s_msb_receiver #(
  parameter int SLOTS       = 2,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_BITS   = 3
) (
  input  logic                clk_x4_i,
  input  logic                reset_ni,
  input  logic                i2s_data_i,
  input  logic                i2s_bclk_i,
  input  logic                i2s_lrclk_i,
  input  logic                i2s_running_i,
  i2s_msb_receiver_if.master  stream,
  output logic                overflow_o,
  input  logic                clr_i,
  output logic                frame_err_o
);
  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int BIT_W   = $clog2(SLOT_BITS);
  localparam int DEPTH   = 2 ** FIFO_BITS;
  localparam int CNT_W   = FIFO_BITS + 1;
  localparam int ENTRY_W = SLOT_W + SAMPLE_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HUNT    = 2'b01,
    CAPTURE = 2'b10
  } state_t;

  state_t                   state_r;
  logic                     data_r, bclk_r, bclk_d_r, lrclk_r, lrclk_prev_r;
  logic [BIT_W-1:0]         bit_r;
  logic [SLOT_W-1:0]        slot_r;
  logic [SAMPLE_BITS-2:0]   shift_r;
  logic                     frame_err_r, overflow_r, valid_r;
  logic [ENTRY_W-1:0]       mem_r [DEPTH];
  logic [ENTRY_W-1:0]       head_r;
  logic [FIFO_BITS-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]         count_r;

  logic                     bclk_rise_s, frame_start_s, frame_pos0_s;
  logic                     push_s, pop_s, full_s, do_push_s, drop_s;
  logic [ENTRY_W-1:0]       wdata_s, head_next_s;
  logic [FIFO_BITS-1:0]     rd_ptr_next_s;
  logic [CNT_W-1:0]         count_next_s;

  assign bclk_rise_s   = bclk_r & ~bclk_d_r;
  assign frame_start_s = bclk_rise_s & lrclk_r & ~lrclk_prev_r;
  // Counters hold the position of the next expected bit; position 0 must be a frame start.
  assign frame_pos0_s  = (bit_r == '0) && (slot_r == '0);
  assign push_s        = i2s_running_i && (state_r == CAPTURE) && bclk_rise_s &&
                         !frame_start_s && (bit_r == BIT_W'(SAMPLE_BITS - 1));
  assign wdata_s       = {slot_r, shift_r, data_r};

  assign pop_s     = valid_r & stream.ready_i;
  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign do_push_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;

  // Input registers and previous-edge history for bclk/lrclk detection.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_r       <= 1'b0;
      bclk_r       <= 1'b0;
      bclk_d_r     <= 1'b0;
      lrclk_r      <= 1'b0;
      lrclk_prev_r <= 1'b0;
    end else begin
      data_r   <= i2s_data_i;
      bclk_r   <= i2s_bclk_i;
      bclk_d_r <= bclk_r;
      lrclk_r  <= i2s_lrclk_i;
      if (bclk_rise_s) begin
        lrclk_prev_r <= lrclk_r;
      end else begin
        lrclk_prev_r <= lrclk_prev_r;
      end
    end
  end

  // Framing state machine: bit/slot counters, shift register and error pulse.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r     <= IDLE;
      bit_r       <= '0;
      slot_r      <= '0;
      shift_r     <= '0;
      frame_err_r <= 1'b0;
    end else if (!i2s_running_i) begin
      state_r     <= IDLE;
      bit_r       <= '0;
      slot_r      <= '0;
      shift_r     <= '0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= HUNT;
        end
        HUNT: begin
          if (frame_start_s) begin
            state_r <= CAPTURE;
            bit_r   <= BIT_W'(1);
            slot_r  <= '0;
            shift_r <= {shift_r[SAMPLE_BITS-3:0], data_r};
          end
        end
        CAPTURE: begin
          if (bclk_rise_s) begin
            if (frame_start_s) begin
              // An early frame start restarts the frame at this bit.
              frame_err_r <= !frame_pos0_s;
              bit_r       <= BIT_W'(1);
              slot_r      <= '0;
              shift_r     <= {shift_r[SAMPLE_BITS-3:0], data_r};
            end else if (frame_pos0_s) begin
              frame_err_r <= 1'b1;
              state_r     <= HUNT;
              bit_r       <= '0;
              slot_r      <= '0;
            end else begin
              shift_r <= {shift_r[SAMPLE_BITS-3:0], data_r};
              if (bit_r == BIT_W'(SLOT_BITS - 1)) begin
                bit_r  <= '0;
                slot_r <= (slot_r == SLOT_W'(SLOTS - 1)) ? '0 : slot_r + 1'b1;
              end else begin
                bit_r <= bit_r + 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next occupancy, read pointer and show-ahead head (bypass when the push becomes head).
  always_comb begin
    count_next_s  = count_r;
    rd_ptr_next_s = rd_ptr_r;
    if (do_push_s && !pop_s) begin
      count_next_s = count_r + 1'b1;
    end else if (!do_push_s && pop_s) begin
      count_next_s = count_r - 1'b1;
    end else begin
      count_next_s = count_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = wdata_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage, pointers, registered head/valid and sticky overflow.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      head_r     <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      valid_r  <= (count_next_s != '0);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_i) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign stream.sample_o = head_r[SAMPLE_BITS-1:0];
  assign stream.slot_o   = head_r[ENTRY_W-1 -: SLOT_W];
  assign stream.valid_o  = valid_r;
  assign overflow_o      = overflow_r;
  assign frame_err_o     = frame_err_r;
endmodule

// File: tb/tb_i2s_msb_receiver.sv
// Directed bench for i2s_msb_receiver: drives bclk/lrclk/data bit by bit and
// checks popped {slot, sample} entries, overflow and framing-error pulses.
module tb_i2s_msb_receiver;
  logic clk = 1'b0;
  logic reset_ni, data, bclk, lrclk, running, overflow, clr, frame_err;

  i2s_msb_receiver_if #(.SAMPLE_BITS(24), .SLOT_W(1)) rx_if ();

  i2s_msb_receiver dut (
    .clk_x4_i      (clk),
    .reset_ni      (reset_ni),
    .i2s_data_i    (data),
    .i2s_bclk_i    (bclk),
    .i2s_lrclk_i   (lrclk),
    .i2s_running_i (running),
    .stream        (rx_if),
    .overflow_o    (overflow),
    .clr_i         (clr),
    .frame_err_o   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [24:0] popped [$];
  logic [24:0] expq [$];

  // Consumer-side monitor: records every pop and every framing-error pulse.
  always @(negedge clk) begin
    if (rx_if.valid_o && rx_if.ready_i) popped.push_back({rx_if.slot_o, rx_if.sample_o});
    if (frame_err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pops(input string tag);
    chk({tag, "_count"}, popped.size(), expq.size());
    for (int i = 0; i < expq.size() && i < popped.size(); i++) chk(tag, popped[i], expq[i]);
    popped.delete();
    expq.delete();
  endtask

  task automatic send_bit(input logic d, input logic lr);
    @(posedge clk); #1; bclk = 1'b0; data = d; lrclk = lr;
    @(posedge clk); @(posedge clk); #1; bclk = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_slot(input logic [23:0] s, input logic lr, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit((i < 24) ? s[23 - i] : 1'b1, lr);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(l, 1'b1, 32);
    send_slot(r, 1'b0, 32);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_ni = 1'b0; data = 1'b0; bclk = 1'b1; lrclk = 1'b0; running = 1'b0; clr = 1'b0;
    rx_if.ready_i = 1'b0;
    idle_cycles(4);
    @(negedge clk);
    chk("rst_valid", rx_if.valid_o, 1'b0);
    chk("rst_sample", rx_if.sample_o, 24'h000000);
    chk("rst_slot", rx_if.slot_o, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    @(posedge clk); #1; reset_ni = 1'b1;
    idle_cycles(2);

    // Mid-frame start, then two good frames with ready high
    running = 1'b1;
    rx_if.ready_i = 1'b1;
    send_slot(24'h000000, 1'b0, 20);
    chk("midframe_no_pop", popped.size(), 32'd0);
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    idle_cycles(10);
    expq = '{{1'b0, 24'hA5A5A5}, {1'b1, 24'h5A5A5A}, {1'b0, 24'hA5A5A5}, {1'b1, 24'h5A5A5A}};
    compare_pops("basic");
    chk("basic_no_err", err_pulses, 32'd0);

    // Overflow: ten samples into an eight-entry FIFO
    rx_if.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    idle_cycles(4);
    chk("ovf_valid", rx_if.valid_o, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", {rx_if.slot_o, rx_if.sample_o}, {1'b0, 24'h100000});
    rx_if.ready_i = 1'b1;
    idle_cycles(20);
    for (int i = 0; i < 4; i++) begin
      expq.push_back({1'b0, 24'h100000 + 24'(i)});
      expq.push_back({1'b1, 24'h200000 + 24'(i)});
    end
    compare_pops("ovf_drain");
    chk("ovf_empty", rx_if.valid_o, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    clr = 1'b1;
    idle_cycles(1);
    clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 1'b0);
    chk("ovf_no_err", err_pulses, 32'd0);

    // Early frame start after 40 bits
    send_slot(24'h123456, 1'b1, 32);
    send_slot(24'h000000, 1'b0, 8);
    send_frame(24'hABCDEF, 24'h654321);
    idle_cycles(10);
    chk("early_err", err_pulses, 32'd1);
    expq = '{{1'b0, 24'h123456}, {1'b0, 24'hABCDEF}, {1'b1, 24'h654321}};
    compare_pops("early");

    // lrclk held low for 70 bits, then resync
    err_pulses = 0;
    send_slot(24'h111111, 1'b1, 32);
    send_slot(24'h222222, 1'b0, 32);
    send_slot(24'h000000, 1'b0, 38);
    chk("late_err", err_pulses, 32'd1);
    send_frame(24'h333333, 24'h444444);
    idle_cycles(10);
    chk("late_err_once", err_pulses, 32'd1);
    expq = '{{1'b0, 24'h111111}, {1'b1, 24'h222222}, {1'b0, 24'h333333}, {1'b1, 24'h444444}};
    compare_pops("late");

    // Running dropped mid-slot: partial sample discarded, queue kept
    err_pulses = 0;
    rx_if.ready_i = 1'b0;
    send_frame(24'h777777, 24'h888888);
    send_slot(24'h999999, 1'b1, 10);
    running = 1'b0;
    idle_cycles(6);
    running = 1'b1;
    idle_cycles(2);
    chk("run_hold_valid", rx_if.valid_o, 1'b1);
    send_slot(24'hEEEEEE, 1'b1, 22);
    send_slot(24'hEEEEEE, 1'b0, 32);
    send_frame(24'hCCCCCC, 24'hDDDDDD);
    idle_cycles(4);
    chk("run_no_pop_held", popped.size(), 32'd0);
    rx_if.ready_i = 1'b1;
    idle_cycles(12);
    expq = '{{1'b0, 24'h777777}, {1'b1, 24'h888888}, {1'b0, 24'hCCCCCC}, {1'b1, 24'hDDDDDD}};
    compare_pops("run_drop");
    chk("run_no_err", err_pulses, 32'd0);
    chk("run_no_ovf", overflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
